// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: FSM encoding and width defaults.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned INSTR_W_DEF = 32;
  localparam int unsigned WORD_BYTES  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush, combinational head read and occupancy count.
module fetch_queue #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, drives instruction memory, buffers words for decode.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned          ADDR_W   = ADDR_W_DEF,
  parameter int unsigned          INSTR_W  = INSTR_W_DEF,
  parameter int unsigned          DEPTH    = 2,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [1:0]         state_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned QW    = INSTR_W + ADDR_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus4;
  logic [CNT_W-1:0]  count;
  logic [QW-1:0]     head;
  logic              empty, push, pop, q_pop;

  assign pc_plus4  = pc_q + ADDR_W'(WORD_BYTES);
  assign empty     = (count == '0);
  assign out_valid = !empty;
  assign pop       = out_valid & out_ready;
  // A redirect discards the whole queue, so a coincident pop must not move rd_ptr.
  assign q_pop     = pop & !branch_taken;
  assign push      = (state_q == S_RUN) & fetch_en & ((count < CNT_W'(DEPTH)) | pop)
                   & !branch_taken;

  assign out_instr = out_valid ? head[QW-1:ADDR_W] : '0;
  assign out_pc    = out_valid ? head[ADDR_W-1:0] : '0;
  assign imem_addr = pc_q;
  assign state_o   = state_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_IDLE:  if (fetch_en) state_d = S_RUN;
      S_RUN:   if (!fetch_en) state_d = S_HOLD;
      S_HOLD: begin
        if (fetch_en)   state_d = S_RUN;
        else if (empty) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (branch_taken) pc_d = {branch_addr[ADDR_W-1:2], 2'b00};
    else if (push)    pc_d = pc_plus4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_queue #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (branch_taken),
    .push  (push),
    .wdata ({imem_rdata, pc_plus4}),
    .pop   (q_pop),
    .rdata (head),
    .count (count)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer with a small combinational memory model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [1:0]  state_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hE3A00014;
    if (a == 32'h4) return 32'hE3A01A01;
    return {8'hC0, a[23:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_sequencer #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .DEPTH    (2),
    .RESET_PC (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .state_o      (state_o)
  );

  typedef struct {
    bit          rst;
    bit          fe;
    bit          rdy;
    bit          br;
    logic [31:0] baddr;
    bit          ev;     // expected out_valid
    logic [31:0] ehead;  // fetch address of expected head word
    logic [31:0] eimem;  // expected imem_addr (pc)
    logic [1:0]  est;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit fe, bit rdy, bit br, logic [31:0] ba,
                              bit ev, logic [31:0] eh, logic [31:0] ei, logic [1:0] es);
    vec_t v;
    v.rst = r; v.fe = fe; v.rdy = rdy; v.br = br; v.baddr = ba;
    v.ev = ev; v.ehead = eh; v.eimem = ei; v.est = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit ev, input logic [31:0] ehead,
                           input logic [31:0] eimem, input logic [1:0] est);
    check({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, ev});
    check({tag, " out_instr"}, out_instr, ev ? mem_word(ehead) : 32'h0);
    check({tag, " out_pc"}, out_pc, ev ? ehead + 32'd4 : 32'h0);
    check({tag, " imem_addr"}, imem_addr, eimem);
    check({tag, " state_o"}, {30'd0, state_o}, {30'd0, est});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    #12;
    rst = 1'b0;
    check_all("reset", 1'b0, 32'h0, 32'h0, 2'd0);

    // Basic stream
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,   0, 32'h0,   32'h0,   2'd1));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,   1, 32'h0,   32'h4,   2'd1));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,   1, 32'h4,   32'h8,   2'd1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,   0, 32'h0,   32'h0,   2'd0));
    // Backpressure from empty: two pushes, then pc frozen at 8
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   32'h0,   2'd1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,   1, 32'h0,   32'h4,   2'd1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,   1, 32'h0,   32'h8,   2'd1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,   1, 32'h0,   32'h8,   2'd1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,   1, 32'h0,   32'h8,   2'd1));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,   1, 32'h4,   32'hC,   2'd1));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,   1, 32'h8,   32'h10,  2'd1));
    // Branch with two words queued, no pop
    vecs.push_back(mk(0, 1, 0, 1, 32'd112, 0, 32'h0,   32'd112, 2'd1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,   1, 32'd112, 32'd116, 2'd1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,   1, 32'd112, 32'd120, 2'd1));
    // Branch and pop together on a full queue; low target bits ignored
    vecs.push_back(mk(0, 1, 1, 1, 32'h203, 0, 32'h0,   32'h200, 2'd1));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,   1, 32'h200, 32'h204, 2'd1));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,   1, 32'h204, 32'h208, 2'd1));
    // fetch_en drop with two queued: HOLD, drain, IDLE, resume at same pc
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,   1, 32'h204, 32'h20C, 2'd1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   1, 32'h204, 32'h20C, 2'd2));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,   1, 32'h208, 32'h20C, 2'd2));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,   0, 32'h0,   32'h20C, 2'd2));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,   0, 32'h0,   32'h20C, 2'd0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,   0, 32'h0,   32'h20C, 2'd1));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,   1, 32'h20C, 32'h210, 2'd1));
    // Branch while IDLE updates pc only
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,   0, 32'h0,   32'h210, 2'd2));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,   0, 32'h0,   32'h210, 2'd0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h40,  0, 32'h0,   32'h40,  2'd0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,   0, 32'h0,   32'h40,  2'd1));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,   1, 32'h40,  32'h44,  2'd1));
    // pc+4 wrap at the top of the address space
    vecs.push_back(mk(0, 1, 1, 1, 32'hFFFFFFFC, 0, 32'h0, 32'hFFFFFFFC, 2'd1));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,   1, 32'hFFFFFFFC, 32'h0, 2'd1));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,   1, 32'h0,   32'h4,   2'd1));

    foreach (vecs[i]) begin
      rst          = vecs[i].rst;
      fetch_en     = vecs[i].fe;
      out_ready    = vecs[i].rdy;
      branch_taken = vecs[i].br;
      branch_addr  = vecs[i].baddr;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ehead, vecs[i].eimem, vecs[i].est);
    end

    // Async reset between clock edges must take effect without an edge
    #3;
    rst = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 32'h0, 32'h0, 2'd0);
    #2;
    rst = 1'b0;
    fetch_en = 1'b0;
    step();
    check_all("post_rst", 1'b0, 32'h0, 32'h0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, required finish before 100000");
    $fatal(1);
  end

endmodule
